ntt8_seq_ctrl: RTL and testbench

//  Sequencing controller for an 8-point forward NTT: streams in 8 coefficients, bit-reverse stores

---
 rtl/ntt8_seq_ctrl.sv | 176 +++++++++++++++++
 tb/tb_ntt8_seq_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ntt8_seq_ctrl.sv
// Sequential 8-point forward NTT: bit-reversed load, 12 shared radix-2 DIT
// butterflies over three stages, then a natural-order result stream.
module ntt8_seq_ctrl #(
    parameter int DATA_W = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_W-1:0]     mod_i,
    input  logic [4*DATA_W-1:0]   omegas_i,
    input  logic [DATA_W-1:0]     in_data_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic [DATA_W-1:0]     out_data_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int STAGES = 3;

    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_COMPUTE = 2'd1,
        S_OUTPUT  = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    logic [DATA_W-1:0]            mem_q [8];
    logic [DATA_W-1:0]            mod_q;
    logic [3:0][DATA_W-1:0]       om_q;

    function automatic logic [2:0] bitrev3(input logic [2:0] n);
        return {n[0], n[1], n[2]};
    endfunction

    function automatic logic [DATA_W-1:0] mod_add(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b,
                                                  input logic [DATA_W-1:0] q);
        logic [DATA_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, q}) s = s - {1'b0, q};
        return s[DATA_W-1:0];
    endfunction

    // A borrow out of the DATA_W+1 bit difference means a < b; adding q once fixes it.
    function automatic logic [DATA_W-1:0] mod_sub(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b,
                                                  input logic [DATA_W-1:0] q);
        logic [DATA_W:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[DATA_W]) d = d + {1'b0, q};
        return d[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] mod_mul(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b,
                                                  input logic [DATA_W-1:0] q);
        logic [2*DATA_W-1:0] p;
        logic [2*DATA_W-1:0] r;
        p = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
        r = p % {{DATA_W{1'b0}}, q};
        return r[DATA_W-1:0];
    endfunction

    logic [1:0]        stage;
    logic [1:0]        bfj;
    logic [2:0]        half, kk, top, bot, wsh;
    logic [DATA_W-1:0] tw, prod, bf_top, bf_bot;

    // Butterfly addressing: cnt_q[3:2] is the stage, cnt_q[1:0] the butterfly within it.
    always_comb begin
        stage  = cnt_q[3:2];
        bfj    = cnt_q[1:0];
        half   = 3'd1 << stage;
        kk     = {1'b0, bfj} & (half - 3'd1);
        top    = (({1'b0, bfj} >> stage) << (stage + 2'd1)) + kk;
        bot    = top + half;
        wsh    = kk << (2'd2 - stage);
        tw     = om_q[wsh[1:0]];
        prod   = mod_mul(tw, mem_q[bot], mod_q);
        bf_top = mod_add(mem_q[top], prod, mod_q);
        bf_bot = mod_sub(mem_q[top], prod, mod_q);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;
        case (state_q)
            S_LOAD: begin
                if (in_valid_i) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_d   = 4'd0;
                        state_d = S_COMPUTE;
                    end
                end
            end
            S_COMPUTE: begin
                cnt_d = cnt_q + 4'd1;
                // X[0] is final after stage 2 butterfly 0, so it can be presented
                // in the same edge that performs the last butterfly.
                if (cnt_q == 4'(STAGES * 4 - 1)) begin
                    cnt_d       = 4'd0;
                    state_d     = S_OUTPUT;
                    out_valid_d = 1'b1;
                    out_data_d  = mem_q[0];
                end
            end
            S_OUTPUT: begin
                if (out_ready_i) begin
                    if (cnt_q == 4'd7) begin
                        cnt_d       = 4'd0;
                        state_d     = S_LOAD;
                        out_valid_d = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        cnt_d      = cnt_q + 4'd1;
                        out_data_d = mem_q[cnt_q[2:0] + 3'd1];
                    end
                end
            end
            default: begin
                state_d     = S_LOAD;
                cnt_d       = 4'd0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_LOAD;
            cnt_q       <= 4'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
        end
    end

    // Working buffer and latched frame parameters carry no reset.
    always_ff @(posedge clk_i) begin
        if (state_q == S_LOAD && in_valid_i) begin
            mem_q[bitrev3(cnt_q[2:0])] <= in_data_i;
            if (cnt_q == 4'd0) begin
                mod_q <= mod_i;
                om_q  <= omegas_i;
            end
        end
        if (state_q == S_COMPUTE) begin
            mem_q[top] <= bf_top;
            mem_q[bot] <= bf_bot;
        end
    end

    assign in_ready_o  = (state_q == S_LOAD);
    assign busy_o      = (state_q != S_LOAD);
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_ntt8_seq_ctrl.sv
// Directed bench for ntt8_seq_ctrl: known transforms, latency, backpressure,
// mid-frame reset, latched modulus and a direct O(N^2) NTT reference.
module tb_ntt8_seq_ctrl;

    typedef logic [7:0] vec_t [8];

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  mod;
    logic [31:0] omegas;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    ntt8_seq_ctrl #(.DATA_W(8)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .mod_i      (mod),
        .omegas_i   (omegas),
        .in_data_i  (in_data),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .out_data_o (out_data),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .busy_o     (busy),
        .done_o     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Direct transform X[k] = sum x[n] * w^(n*k mod 8) mod q.
    function automatic vec_t ntt_ref(input vec_t x, input int q, input int w);
        int   wp [8];
        int   acc;
        vec_t r;
        wp[0] = 1;
        for (int m = 1; m < 8; m++) wp[m] = (wp[m-1] * w) % q;
        for (int k = 0; k < 8; k++) begin
            acc = 0;
            for (int n = 0; n < 8; n++) acc = (acc + int'(x[n]) * wp[(n * k) % 8]) % q;
            r[k] = 8'(acc);
        end
        return r;
    endfunction

    task automatic send(input vec_t x);
        for (int n = 0; n < 8; n++) begin
            in_data  = x[n];
            in_valid = 1'b1;
            check("in_ready_load", in_ready, 1);
            tick();
        end
        in_valid = 1'b0;
        in_data  = 8'd0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 60) begin
            tick();
            lat++;
        end
    endtask

    task automatic recv(input logic bp, output vec_t y);
        int         got   = 0;
        int         guard = 0;
        logic       held_v = 1'b0;
        logic [7:0] held  = 8'd0;
        for (int k = 0; k < 8; k++) y[k] = 8'hxx;
        while (got < 8 && guard < 200) begin
            if (held_v) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, held);
            end
            check("in_ready_busy", in_ready, 0);
            check("busy_high", busy, 1);
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            held_v = out_valid && !out_ready;
            held   = out_data;
            if (out_valid && out_ready) begin
                y[got] = out_data;
                got++;
            end
            tick();
            guard++;
        end
        out_ready = 1'b0;
        check("beat_count", got, 8);
        check("done_pulse", done, 1);
        check("in_ready_with_done", in_ready, 1);
        check("busy_after", busy, 0);
        check("out_valid_after", out_valid, 0);
    endtask

    task automatic run_frame(input string tag, input vec_t x, input vec_t exp, input logic bp);
        int   lat;
        vec_t y;
        send(x);
        wait_valid(lat);
        check({tag, "_latency"}, lat, 13);
        recv(bp, y);
        for (int k = 0; k < 8; k++) check($sformatf("%s_X%0d", tag, k), y[k], exp[k]);
    endtask

    initial begin
        vec_t x_delta, x_const, x_shift, x_rand;
        vec_t e_delta, e_const, e_shift, e_rand, y;
        int   lat;
        int   q;

        x_delta = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        e_delta = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
        x_const = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
        e_const = '{8'd8, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        x_shift = '{8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        e_shift = '{8'd1, 8'd2, 8'd4, 8'd8, 8'd16, 8'd15, 8'd13, 8'd9};

        rst       = 1'b1;
        mod       = 8'd17;
        omegas    = {8'd8, 8'd4, 8'd2, 8'd1};
        in_data   = 8'd0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        tick();

        // Delta input: flat spectrum; done falls after one cycle.
        run_frame("delta", x_delta, e_delta, 1'b0);
        tick();
        check("done_one_cycle", done, 0);

        run_frame("const", x_const, e_const, 1'b0);

        // Shift input with junk in_valid during COMPUTE that must be ignored.
        send(x_shift);
        in_valid = 1'b1;
        in_data  = 8'd5;
        wait_valid(lat);
        in_valid = 1'b0;
        in_data  = 8'd0;
        check("shift_latency", lat, 13);
        recv(1'b0, y);
        for (int k = 0; k < 8; k++) check($sformatf("shift_X%0d", k), y[k], e_shift[k]);

        run_frame("bp", x_shift, e_shift, 1'b1);

        // Asynchronous reset in the fifth COMPUTE cycle.
        send(x_delta);
        tick();
        tick();
        tick();
        tick();
        check("pre_rst_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        #2 rst = 1'b0;
        tick();
        check("post_rst_out_valid", out_valid, 0);
        run_frame("after_rst", x_const, e_const, 1'b0);

        // Modulus and twiddles changed while frame 1 computes; frame 2 follows directly.
        send(x_shift);
        mod    = 8'd29;
        omegas = {8'd3, 8'd7, 8'd11, 8'd13};
        wait_valid(lat);
        check("latched_latency", lat, 13);
        recv(1'b0, y);
        for (int k = 0; k < 8; k++) check($sformatf("latched_X%0d", k), y[k], e_shift[k]);
        mod    = 8'd17;
        omegas = {8'd8, 8'd4, 8'd2, 8'd1};
        run_frame("b2b", x_const, e_const, 1'b0);

        // Random frames against the direct reference, at q=17 (w=2) and q=41 (w=3).
        for (int f = 0; f < 40; f++) begin
            if (f % 2 == 0) begin
                q      = 17;
                omegas = {8'd8, 8'd4, 8'd2, 8'd1};
                e_rand = e_delta;
            end else begin
                q      = 41;
                omegas = {8'd27, 8'd9, 8'd3, 8'd1};
            end
            mod = 8'(q);
            for (int n = 0; n < 8; n++) x_rand[n] = 8'($urandom_range(0, q - 1));
            e_rand = ntt_ref(x_rand, q, (q == 17) ? 2 : 3);
            run_frame($sformatf("rand%0d", f), x_rand, e_rand, f % 3 == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
